// File: rtl/per2axi_req_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the per2axi request arbiter.
package per2axi_req_arbiter_pkg;

  localparam logic PER_WE_WRITE = 1'b0;
  localparam logic PER_WE_READ  = 1'b1;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/per2axi_req_arbiter_if.sv
// Initiator-side and downstream-side signals of the per2axi request arbiter.
interface per2axi_req_arbiter_if #(
  parameter int NB_REQ         = 4,
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5
);

  // initiator side
  logic [NB_REQ-1:0]                     per_req_i;
  logic [NB_REQ-1:0][PER_ADDR_WIDTH-1:0] per_add_i;
  logic [NB_REQ-1:0]                     per_we_i;
  logic [NB_REQ-1:0][31:0]               per_wdata_i;
  logic [NB_REQ-1:0][3:0]                per_be_i;
  logic [NB_REQ-1:0][PER_ID_WIDTH-1:0]   per_id_i;
  logic [NB_REQ-1:0]                     per_gnt_o;
  logic [NB_REQ-1:0]                     per_r_valid_o;
  logic [31:0]                           per_r_rdata_o;
  logic                                  per_r_opc_o;

  // downstream side
  logic                                  out_req_o;
  logic [PER_ADDR_WIDTH-1:0]             out_add_o;
  logic                                  out_we_o;
  logic [31:0]                           out_wdata_o;
  logic [3:0]                            out_be_o;
  logic [PER_ID_WIDTH-1:0]               out_id_o;
  logic                                  out_gnt_i;
  logic                                  out_r_valid_i;
  logic [31:0]                           out_r_rdata_i;
  logic                                  out_r_opc_i;

  modport slave (
    input  per_req_i, per_add_i, per_we_i, per_wdata_i, per_be_i, per_id_i,
    output per_gnt_o, per_r_valid_o, per_r_rdata_o, per_r_opc_o,
    output out_req_o, out_add_o, out_we_o, out_wdata_o, out_be_o, out_id_o,
    input  out_gnt_i, out_r_valid_i, out_r_rdata_i, out_r_opc_i
  );

  modport master (
    output per_req_i, per_add_i, per_we_i, per_wdata_i, per_be_i, per_id_i,
    input  per_gnt_o, per_r_valid_o, per_r_rdata_o, per_r_opc_o,
    input  out_req_o, out_add_o, out_we_o, out_wdata_o, out_be_o, out_id_o,
    output out_gnt_i, out_r_valid_i, out_r_rdata_i, out_r_opc_i
  );

endinterface

// File: rtl/per2axi_req_arb_fifo.sv
// Index FIFO recording which initiator owns each outstanding transaction, oldest at head.
module per2axi_req_arb_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW:0]                 wr_ptr_q, rd_ptr_q;

  // extra pointer bit separates full from empty when the slot indices match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/per2axi_req_arbiter.sv
// Round-robin arbiter sharing one per2axi slave port between NB_REQ initiators,
// with request lock until downstream grant and in-order response routing.
module per2axi_req_arbiter
  import per2axi_req_arbiter_pkg::*;
#(
  parameter int NB_REQ          = 4,
  parameter int PER_ADDR_WIDTH  = 32,
  parameter int PER_ID_WIDTH    = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  per2axi_req_arbiter_if.slave               bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int IW = $clog2(NB_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, lock_q, lock_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [NB_REQ-1:0][IW-1:0] cand;
  logic [IW-1:0] arb_sel, sel, sel_nxt, fifo_head;
  logic          found, any_req, below_max, out_req, hs, rsp_ok;
  logic          fifo_full, fifo_empty, fifo_push;

  logic [PER_ADDR_WIDTH-1:0] add_sel;
  logic [PER_ID_WIDTH-1:0]   id_sel;

  // candidate order: rr_q, rr_q+1, ... wrapping at NB_REQ (NB_REQ need not be a power of two)
  for (genvar i = 0; i < NB_REQ; i++) begin : g_cand
    assign cand[i] = IW'((int'(rr_q) + i) % NB_REQ);
  end

  always_comb begin
    arb_sel = rr_q;
    found   = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (!found && bus.per_req_i[cand[i]]) begin
        arb_sel = cand[i];
        found   = 1'b1;
      end
    end
  end

  assign any_req   = |bus.per_req_i;
  assign below_max = (cnt_q < CW'(MAX_OUTSTANDING));
  assign sel       = (state_q == LOCK) ? lock_q : arb_sel;
  assign sel_nxt   = (sel == IW'(NB_REQ - 1)) ? '0 : sel + IW'(1);

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      rr_q    <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    unique case (state_q)
      ARB: begin
        if (out_req && !bus.out_gnt_i) begin
          state_d = LOCK;
          lock_d  = arb_sel;
        end
      end
      LOCK: begin
        if (bus.out_gnt_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (hs) rr_d = sel_nxt;
  end

  // outputs; reset forces the request low even while initiators keep asking
  always_comb begin
    out_req = 1'b0;
    unique case (state_q)
      ARB:     out_req = below_max & any_req;
      LOCK:    out_req = 1'b1;
      default: out_req = 1'b0;
    endcase
    if (rst_i) out_req = 1'b0;
  end

  assign hs = out_req & bus.out_gnt_i;

  assign add_sel = bus.per_add_i[sel];
  assign id_sel  = bus.per_id_i[sel];

  assign bus.out_req_o   = out_req;
  assign bus.out_add_o   = add_sel;
  assign bus.out_we_o    = bus.per_we_i[sel];
  assign bus.out_wdata_o = bus.per_wdata_i[sel];
  assign bus.out_be_o    = bus.per_be_i[sel];
  assign bus.out_id_o    = id_sel;

  // a response only counts when something is in flight; otherwise it is flagged
  assign rsp_ok = bus.out_r_valid_i & ~fifo_empty;
  assign err_d  = err_q | (bus.out_r_valid_i & fifo_empty);

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !rsp_ok && cnt_q != CW'(MAX_OUTSTANDING)) cnt_d = cnt_q + CW'(1);
    else if (!hs && rsp_ok)                             cnt_d = cnt_q - CW'(1);
  end

  assign fifo_push = hs & (~fifo_full | rsp_ok);

  per2axi_req_arb_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (sel),
    .pop_i   (rsp_ok),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  for (genvar i = 0; i < NB_REQ; i++) begin : g_lane
    assign bus.per_gnt_o[i]     = hs & (sel == IW'(i));
    assign bus.per_r_valid_o[i] = rsp_ok & (fifo_head == IW'(i));
  end

  assign bus.per_r_rdata_o = bus.out_r_rdata_i;
  assign bus.per_r_opc_o   = bus.out_r_opc_i;
  assign outstanding_o     = cnt_q;
  assign err_o             = err_q;

endmodule

// File: doc/per2axi_req_arbiter.md
Name: per2axi_req_arbiter

Overview:
Shares one per2axi peripheral slave port between NB_REQ peripheral-interconnect initiators.
- Round-robin arbitration with a lock that holds the selected request stable until the downstream grant arrives.
- Tracks outstanding transactions up to MAX_OUTSTANDING.
- Routes in-order responses back to the originating initiator through an index FIFO.
- Sits between the cluster peripheral interconnect and the per2axi request/response channels.

Parameters:
- NB_REQ, 4, number of initiator ports (2..16).
- PER_ADDR_WIDTH, 32, peripheral address width.
- PER_ID_WIDTH, 5, peripheral one-hot ID width.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered transactions; power of two, >=2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- per_req_i  in  NB_REQ  initiator request.
- per_add_i  in  NB_REQ x PER_ADDR_WIDTH  initiator address.
- per_we_i  in  NB_REQ  0 = write, 1 = read (peripheral interconnect convention).
- per_wdata_i  in  NB_REQ x 32  write data.
- per_be_i  in  NB_REQ x 4  byte enables.
- per_id_i  in  NB_REQ x PER_ID_WIDTH  one-hot ID.
- per_gnt_o  out  NB_REQ  grant; at most one bit set.
- per_r_valid_o  out  NB_REQ  response valid; at most one bit set.
- per_r_rdata_o  out  32  response data, shared by all initiators.
- per_r_opc_o  out  1  response error flag, shared.
- out_req_o  out  1  downstream request.
- out_add_o  out  PER_ADDR_WIDTH  downstream address.
- out_we_o  out  1  downstream write enable.
- out_wdata_o  out  32  downstream write data.
- out_be_o  out  4  downstream byte enables.
- out_id_o  out  PER_ID_WIDTH  downstream ID.
- out_gnt_i  in  1  downstream grant.
- out_r_valid_i  in  1  downstream response valid.
- out_r_rdata_i  in  32  downstream response data.
- out_r_opc_i  in  1  downstream response error.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count.
- err_o  out  1  sticky: response received with no transaction outstanding.

Behaviour:
- Reset (async, rst_i=1):
  - all grants, r_valid, out_req_o and err_o are 0.
  - outstanding count 0, rr pointer 0, FSM in ARB, FIFO empty.
  - Reset mid-transaction drops all tracking; no response is routed afterwards until new handshakes occur.
- Handshake = out_req_o & out_gnt_i. A handshake is the only event that grants an initiator.
- FSM ARB:
  - If count < MAX_OUTSTANDING and any per_req_i is set, select the first requester at or after rr_ptr, in circular order.
  - out_req_o=1 and out_* carry the selected payload, combinationally (zero cycle).
  - If out_gnt_i=1 in the same cycle: per_gnt_o[sel]=1, rr_ptr <= sel+1 (mod NB_REQ), stay in ARB.
  - If out_gnt_i=0: register sel into lock_idx and go to LOCK.
- FSM LOCK:
  - out_req_o=1 and the payload is muxed from lock_idx regardless of other requesters.
  - On out_gnt_i=1: per_gnt_o[lock_idx]=1, rr_ptr <= lock_idx+1, go to ARB.
  - The initiator must keep its request stable while locked. If it drops per_req_i, out_req_o stays asserted with its current payload; the behaviour of that initiator is undefined, not the arbiter's.
- Outstanding limit: with count == MAX_OUTSTANDING in ARB, out_req_o=0 and all grants are 0. LOCK is entered only when count < MAX, so LOCK never violates the limit.
- Counter update:
  - +1 on handshake.
  - -1 on out_r_valid_i with count > 0.
  - Both in the same cycle: unchanged.
  - Saturates; never wraps.
- Response routing:
  - The FIFO head holds the initiator index. per_r_valid_o[head] = out_r_valid_i.
  - rdata and opc pass through combinationally (zero cycle).
  - FIFO push on handshake, pop on out_r_valid_i.
  - Simultaneous push and pop on a full FIFO is legal.
- A response arriving when count == 0: no per_r_valid_o, no pop, err_o <= 1. err_o clears only on reset.
- Writes and reads both produce exactly one response each and share one order; the downstream must return responses in order.
- Single initiator with a continuous request: handshake every cycle when out_gnt_i=1 and count < MAX.

Decomposition:
- per2axi_pkg (shared):
  - PER_WE_WRITE=1'b0, PER_WE_READ=1'b1.
  - Response opcode constants OPC_OK=1'b0, OPC_ERR=1'b1.
  - Arbiter FSM state enum {ARB, LOCK}.
- Sub-module per2axi_req_arb_fifo:
  - Synchronous index FIFO, width $clog2(NB_REQ), depth MAX_OUTSTANDING.
  - Ports: push, pop, full, empty, head.
  - Same clock and async active-high reset.

Test Plan:
- Reset then idle: all outputs 0; assert rst_i mid-LOCK -> out_req_o drops asynchronously, outstanding_o=0.
- Round-robin: per_req_i=4'b1111, out_gnt_i=1 constantly, responses returned one cycle later -> grants in order 0,1,2,3,0; one grant per cycle.
- Lock: initiator 2 requests, out_gnt_i=0 for 3 cycles while initiator 0 also requests -> out_add_o stays at initiator 2's address; grant to 2 on cycle 4, then to 0.
- Limit: MAX_OUTSTANDING=4, no responses -> 4 handshakes, then out_req_o=0. One out_r_valid_i -> outstanding_o=3, next request issued the following cycle.
- Routing: issue from initiators 3,1,3 (reads, we=1); return rdata 0xA,0xB,0xC -> per_r_valid_o bits 3,1,3 with matching data. Simultaneous handshake and response leaves the count unchanged.
- Error: out_r_valid_i with outstanding_o=0 -> no per_r_valid_o, err_o=1 and sticky until reset.
